// File: rtl/ram_responder.sv
// Single-port word RAM answering the fetch-stage memory port.
// Single reads/writes plus incrementing read bursts after WAIT_STATES cycles.
module ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_di,
  input  logic                  burst_en,
  output logic [DATA_WIDTH-1:0] mem_do,
  output logic                  do_ack,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    BURST
  } state_t;

  state_t                  st;
  logic [2:0]              wcnt;
  logic [3:0]              bcnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [DATA_WIDTH-1:0]   di_q;
  logic                    we_q;
  logic                    burst_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign addr_nx = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Write lands on the edge that ends the ACK cycle; an async
  // reset before that edge leaves st at IDLE, so nothing is written.
  always_ff @(posedge clk) begin
    if (st == ACK && we_q) mem[addr_q] <= di_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= IDLE;
      wcnt    <= '0;
      bcnt    <= '0;
      addr_q  <= '0;
      di_q    <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      mem_do  <= '0;
      do_ack  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      do_ack <= 1'b0;
      unique case (st)
        IDLE: begin
          if (mem_en) begin
            addr_q  <= mem_addr;
            we_q    <= mem_we;
            di_q    <= mem_di;
            burst_q <= burst_en & ~mem_we;
            busy    <= 1'b1;
            if (WAIT_STATES == 0) begin
              st     <= ACK;
              do_ack <= 1'b1;
              if (!mem_we) mem_do <= mem[mem_addr];
            end else begin
              st   <= WAIT;
              wcnt <= 3'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (wcnt == 3'd0) begin
            st     <= ACK;
            do_ack <= 1'b1;
            if (!we_q) mem_do <= mem[addr_q];
          end else begin
            wcnt <= wcnt - 3'd1;
          end
        end
        ACK: begin
          if (burst_q) begin
            st     <= BURST;
            do_ack <= 1'b1;
            addr_q <= addr_nx;
            mem_do <= mem[addr_nx];
            bcnt   <= 4'(BURST_LEN - 2);
          end else begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        BURST: begin
          if (bcnt == 4'd0) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else begin
            bcnt   <= bcnt - 4'd1;
            do_ack <= 1'b1;
            addr_q <= addr_nx;
            mem_do <= mem[addr_nx];
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Single-port on-chip instruction/data RAM that answers the pipeline's device memory port. It is the responder end of the `mem_en` / `mem_addr` / `mem_di` / `burst_en` → `mem_do` / `do_ack` interface that the instruction-fetch stage drives. It supports single-word reads, single-word writes and fixed-length incrementing read bursts, with a programmable number of wait states.

## Interface
- `ADDR_WIDTH`, 10: word address width; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width.
- `WAIT_STATES`, 1: cycles inserted between request capture and the first `do_ack`; legal range 0..7.
- `BURST_LEN`, 4: words returned per read burst; legal range 2..16.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `mem_en`  in  1  request strobe, sampled only in IDLE.
- `mem_we`  in  1  1 = write, 0 = read; captured with `mem_en`.
- `mem_addr`  in  ADDR_WIDTH  word address; captured with `mem_en`.
- `mem_di`  in  DATA_WIDTH  write data; captured with `mem_en`.
- `burst_en`  in  1  1 = read burst of BURST_LEN words; captured with `mem_en`.
- `mem_do`  out  DATA_WIDTH  read data; valid while `do_ack`=1.
- `do_ack`  out  1  one-cycle pulse per completed word.
- `busy`  out  1  1 in every state except IDLE.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH array. It is not cleared by reset, and its contents survive reset.
- States:
  - IDLE: on a rising edge with `mem_en`=1, capture `mem_addr`, `mem_we`, `mem_di` and `burst_en`. Go to WAIT if WAIT_STATES>0, otherwise go to ACK.
  - WAIT: count down WAIT_STATES cycles, then go to ACK.
  - ACK: `do_ack`=1 for exactly one cycle.
    - Read: `mem_do` = array[captured addr] during this cycle.
    - Write: array[captured addr] ← captured data at the end of this cycle; `mem_do` is unchanged.
    - A single access goes to IDLE. A burst goes to BURST.
  - BURST: `do_ack`=1 on every cycle; the address increments by 1 each cycle, modulo 2^ADDR_WIDTH. Stay until BURST_LEN acks in total have been issued, then go to IDLE.
- `burst_en`=1 with `mem_we`=1 is executed as a single write. The burst flag is ignored.
- `mem_en` and all request inputs are ignored outside IDLE. A request cannot be aborted.
- The requester must drop `mem_en` in the cycle it sees its final `do_ack`. If `mem_en` is still 1 at the first IDLE edge, a new request is captured.
- Read-after-write: a read issued after a write's ack returns the new data.
- Between acks, `mem_do` holds the last read word.
- The address counter is ADDR_WIDTH bits wide; overflow wraps silently, so 0x3FF is followed by 0x000.

## Timing
- Reset values:
  - state = IDLE
  - `do_ack`=0
  - `busy`=0
  - `mem_do`=0
  - wait and burst counters = 0
- Latency: request sampled at edge E. The first `do_ack` is high in the cycle following edge E+WAIT_STATES, so it appears WAIT_STATES+1 cycles after capture.
- A burst's acks occupy BURST_LEN consecutive cycles with no gaps.
- The minimum request-to-request spacing, from capture to next capture, is WAIT_STATES+2 cycles for a single access. This covers the IDLE, WAIT and ACK cycles plus the return to IDLE.
- `busy` rises in the cycle after capture and falls in the cycle after the final ack.
- Asynchronous reset asserted mid-transaction:
  - `do_ack` and `busy` drop immediately.
  - A write whose ACK-cycle edge has not occurred is not performed.
  - The remaining words of a burst are dropped.
- After reset is released, the first rising edge behaves as IDLE.

## Test plan
- Write 0xDEADBEEF to 0x005, then read 0x005 with WAIT_STATES=1.
  - Each access gives a single `do_ack` 2 cycles after capture.
  - The read returns `mem_do`=0xDEADBEEF.
- Preload 0x3FE..0x001 with 0xA0..0xA3, then issue a burst read at 0x3FE with BURST_LEN=4.
  - Four consecutive acks with `mem_do` = 0xA0, 0xA1, 0xA2, 0xA3, showing the address wraps to 0x000.
- With WAIT_STATES=0, read 0x010.
  - `do_ack` appears 1 cycle after capture.
  - With WAIT_STATES=7, `do_ack` appears 8 cycles after capture.
- Hold `mem_en`=1 continuously with reads of 0x001, then 0x002.
  - Back-to-back transactions spaced WAIT_STATES+2 cycles apart.
  - Toggling `mem_en` or `mem_addr` while `busy`=1 has no effect on the transaction in flight.
- Assert `reset`=0 after the 2nd ack of a 4-word burst.
  - `do_ack`, `busy` and `mem_do` go to 0 at once, and no further acks appear.
  - After release, a read of a previously written address returns the preserved data.
- Burst request with `mem_we`=1, data 0x12345678, at 0x020.
  - Exactly one ack.
  - Only 0x020 is written; 0x021 is unchanged.
